// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, redirect/stall/flush
// handling, sticky misaligned-target halt and a retired-fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_IM,
  input  logic [31:0] inst_IM,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        fetch_err,
  output logic [31:0] err_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_nx, id_inst_nx, id_pc_nx, id_pc4_nx, err_pc_nx, fetch_count_nx;
  logic            id_valid_nx, fetch_err_nx;
  logic [XLEN-1:0] pc_plus4_c;

  assign pc_plus4_c = pc_IM + XLEN'(4);

  // Next-state: redirect > flush > stall > normal fetch; HALT only bubbles.
  always_comb begin
    state_nx       = state;
    pc_nx          = pc_IM;
    id_valid_nx    = id_valid;
    id_inst_nx     = id_inst;
    id_pc_nx       = id_pc;
    id_pc4_nx      = id_pc4;
    fetch_err_nx   = fetch_err;
    err_pc_nx      = err_pc;
    fetch_count_nx = fetch_count;
    case (state)
      RUN: begin
        if (redirect) begin
          id_valid_nx = 1'b0;
          id_inst_nx  = NOP;
          if (redirect_pc[1:0] != 2'b00) begin
            fetch_err_nx = 1'b1;
            err_pc_nx    = redirect_pc;
            state_nx     = HALT;
          end else begin
            pc_nx = redirect_pc;
          end
        end else if (flush) begin
          id_valid_nx = 1'b0;
          id_inst_nx  = NOP;
          if (!stall) pc_nx = pc_plus4_c;
        end else if (!stall) begin
          id_valid_nx    = 1'b1;
          id_inst_nx     = inst_IM;
          id_pc_nx       = pc_IM;
          id_pc4_nx      = pc_plus4_c;
          pc_nx          = pc_plus4_c;
          fetch_count_nx = fetch_count + XLEN'(1);
        end
      end
      HALT: begin
        id_valid_nx = 1'b0;
        id_inst_nx  = NOP;
      end
      default: state_nx = RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc_IM       <= RESET_PC;
      id_valid    <= 1'b0;
      id_inst     <= NOP;
      id_pc       <= '0;
      id_pc4      <= '0;
      fetch_err   <= 1'b0;
      err_pc      <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc_IM       <= pc_nx;
      id_valid    <= id_valid_nx;
      id_inst     <= id_inst_nx;
      id_pc       <= id_pc_nx;
      id_pc4      <= id_pc4_nx;
      fetch_err   <= fetch_err_nx;
      err_pc      <= err_pc_nx;
      fetch_count <= fetch_count_nx;
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the rv32i datapath. It holds the program counter, drives the word address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for the decoder. It also handles branch/jump redirects, hazard stalls, flushes, a misaligned-target halt and a retired-fetch counter.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pc_IM  out  32  fetch address to instruction memory; equals PC register
- inst_IM  in  32  instruction word returned combinationally for pc_IM
- redirect  in  1  taken branch/jump from execute
- redirect_pc  in  32  redirect target byte address
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  squash IF/ID contents
- id_valid  out  1  IF/ID holds a real instruction
- id_inst  out  32  IF/ID instruction
- id_pc  out  32  IF/ID instruction address
- id_pc4  out  32  id_pc + 4 (mod 2^32), for JAL/JALR link
- fetch_err  out  1  sticky: misaligned redirect taken
- err_pc  out  32  offending redirect_pc
- fetch_count  out  32  number of valid instructions loaded into IF/ID

## Operation
- States: RUN, HALT. Reset -> RUN. RUN -> HALT when redirect=1 and redirect_pc[1:0]!=0. HALT exits only on reset.
- Reset values: PC=RESET_PC, id_valid=0, id_inst=NOP, id_pc=0, id_pc4=0, fetch_err=0, err_pc=0, fetch_count=0, state=RUN.
- Priority per edge in RUN: redirect > flush > stall > normal.
- Aligned redirect: PC <= redirect_pc; IF/ID <= bubble (valid=0, inst=NOP, pc/pc4 hold). Stall and flush are ignored that cycle.
- Misaligned redirect: PC holds; IF/ID <= bubble; fetch_err <= 1; err_pc <= redirect_pc; state <= HALT.
- flush (no redirect): IF/ID <= bubble. PC <= PC+4 unless stall=1, in which case PC holds.
- stall (no redirect/flush): PC and IF/ID hold all fields. fetch_count holds.
- Normal: IF/ID <= {valid=1, inst_IM, PC, PC+4}; PC <= PC+4; fetch_count <= fetch_count+1.
- HALT: PC frozen; IF/ID forced to bubble each edge; all inputs ignored; fetch_count holds.
- Arithmetic: PC+4 and fetch_count both wrap modulo 2^32. PC bits [1:0] are always 0 except when RESET_PC is misaligned, which is a configuration error and is not checked.

## Timing
- Fetch latency: inst at pc_IM appears on id_inst after exactly 1 edge.
- Redirect asserted in cycle N: pc_IM=target during N+1; id_inst=target's word after edge N+1; one bubble is inserted.
- fetch_err is set at the same edge the misaligned redirect is sampled.
- Asynchronous reset mid-operation: outputs take reset values immediately, without waiting for a clock edge. Fetch resumes from RESET_PC at the first edge after deassertion.
- pc_IM is a pure register output with no combinational path from any input.

## Test plan
- Reset/sequence, program memory loaded (word0=0x00300413, word1=0x00100493): reset released -> edge1 id_inst=0x00300413, id_pc=0, id_pc4=4, valid=1; edge2 id_inst=0x00100493, id_pc=4, fetch_count=2.
- Stall: stall=1 for 2 cycles while id_pc=8 -> id_pc stays 8, pc_IM stays 0xC, fetch_count constant. Then stall=0 -> next id_pc=0xC.
- Redirect plus simultaneous stall and flush, redirect_pc=0x40 -> next edge id_valid=0, pc_IM=0x40. Following edge id_inst=0xff5ff06f, id_pc=0x40.
- Misaligned redirect_pc=0x42 -> fetch_err=1, err_pc=0x42, id_valid=0 forever, pc_IM frozen. Reset clears fetch_err and returns pc_IM to RESET_PC.
- Wrap: RESET_PC=0xFFFFFFFC -> edge1 id_pc=0xFFFFFFFC, id_pc4=0, pc_IM=0.
- Reset pulse between edges mid-run -> id_valid=0, id_inst=0x00000013, fetch_count=0 before the next clock edge.
